// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl.sv
// Scan-chain controller: loads PAT LSB-first, runs CAP_CYC capture cycles, unloads the response.
// Optional MISR signature over unloaded bits when SCAN_SHIFT_CTRL_MISR_EN is defined.
module gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int CAP_CYC   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic [15:0]          SIG
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sh_q, sh_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    resp_d  = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          sh_d    = PAT;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        sh_d = sh_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == LAST_CAP) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UNLOAD: begin
        for (int k = 0; k < CHAIN_LEN; k++) begin
          if (cnt_q == CNT_W'(k)) resp_d[k] = SO;
        end
        if (cnt_q == LAST_BIT) begin
          state_d = ST_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    se_d   = (state_d == ST_LOAD) || (state_d == ST_UNLOAD);
    si_d   = (state_d == ST_LOAD) && sh_d[0];
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: RESP is cleared by reset, unlike a plain storage array, because aborted runs must read back 0.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign RESP = resp_q;

`ifdef SCAN_SHIFT_CTRL_MISR_EN
  // Galois MISR, x^16+x^12+x^5+1, each unloaded bit folded into bit 0.
  localparam logic [15:0] MISR_POLY = 16'h1021;

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == ST_IDLE && START) begin
      sig_d = '0;
    end else if (state_q == ST_UNLOAD) begin
      sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15]}} & MISR_POLY) ^ {15'd0, SO};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign SIG = sig_q;
`else
  assign SIG = 16'h0000;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl.sv
// Bench: two controllers (CAP_CYC 1 and 4) each driving a 16-flop chain whose D input is NOT Q,
// checked every cycle against a schedule model counted in cycles since acceptance.
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl;

  localparam int N = 16;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [N-1:0]         pat;
  logic [1:0]           so, se, si, busy, done;
  logic [1:0][N-1:0]    resp;
  logic [1:0][15:0]     sig;
  logic [1:0][N-1:0]    chain;

  int checks = 0;
  int errors = 0;

  int          cap [2];
  int          d   [2];
  logic [15:0] pat_l  [2];
  logic [15:0] resp_e [2];
  logic [15:0] sig_e  [2];

  gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl #(.CHAIN_LEN(N), .CAP_CYC(1)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .PAT(pat), .SO(so[0]),
    .SE(se[0]), .SI(si[0]), .BUSY(busy[0]), .DONE(done[0]), .RESP(resp[0]), .SIG(sig[0])
  );

  gf180mcu_fd_sc_mcu9t5v0__scan_shift_ctrl #(.CHAIN_LEN(N), .CAP_CYC(4)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .PAT(pat), .SO(so[1]),
    .SE(se[1]), .SI(si[1]), .BUSY(busy[1]), .DONE(done[1]), .RESP(resp[1]), .SIG(sig[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scan flops: shift when SE is high, otherwise capture the inverse of their own Q.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chain[i] <= se[i] ? {chain[i][N-2:0], si[i]} : ~chain[i];
    end
  end
  assign so = {chain[1][N-1], chain[0][N-1]};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: check the current cycle, drive next inputs, advance the model across the edge.
  task automatic step(input logic st, input logic [15:0] p, input logic r);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int   last;
      logic se_x, si_x;
      last = 2 * N + cap[i] + 1;
      se_x = (d[i] >= 1) && ((d[i] <= N) || ((d[i] > N + cap[i]) && (d[i] <= 2 * N + cap[i])));
      si_x = (d[i] >= 1) && (d[i] <= N) && pat_l[i][d[i]-1];
      check($sformatf("se%0d_d%0d", i, d[i]),   {15'd0, se[i]},   {15'd0, se_x});
      check($sformatf("si%0d_d%0d", i, d[i]),   {15'd0, si[i]},   {15'd0, si_x});
      check($sformatf("busy%0d_d%0d", i, d[i]), {15'd0, busy[i]}, {15'd0, logic'(d[i] != 0)});
      check($sformatf("done%0d_d%0d", i, d[i]), {15'd0, done[i]}, {15'd0, logic'(d[i] == last)});
      check($sformatf("resp%0d_d%0d", i, d[i]), resp[i], resp_e[i]);
      check($sformatf("sig%0d_d%0d", i, d[i]),  sig[i],  sig_e[i]);
    end

    start = st;
    pat   = p;
    rst   = r;

    for (int i = 0; i < 2; i++) begin
      int last;
      last = 2 * N + cap[i] + 1;
      if (r) begin
        d[i]      = 0;
        resp_e[i] = '0;
        sig_e[i]  = '0;
      end else if (d[i] == 0) begin
        if (st) begin
          d[i]     = 1;
          pat_l[i] = p;
          sig_e[i] = '0;
        end
      end else begin
        if (d[i] > N + cap[i] && d[i] <= 2 * N + cap[i]) begin
          int   k;
          logic b;
          k = d[i] - N - cap[i] - 1;
          // An odd number of capture inversions flips each loaded bit.
          b = (cap[i] % 2 == 1) ? ~pat_l[i][k] : pat_l[i][k];
          resp_e[i][k] = b;
`ifdef SCAN_SHIFT_CTRL_MISR_EN
          sig_e[i] = {sig_e[i][14:0], 1'b0} ^ (sig_e[i][15] ? 16'h1021 : 16'h0000) ^ {15'd0, b};
`endif
        end
        d[i] = (d[i] == last) ? 0 : d[i] + 1;
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pat   = '0;
    cap   = '{1, 4};
    for (int i = 0; i < 2; i++) begin
      d[i]      = 0;
      pat_l[i]  = '0;
      resp_e[i] = '0;
      sig_e[i]  = '0;
    end
    repeat (2) @(posedge clk);

    // Reset state, with START high to show reset wins.
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 16'h0000, 1'b0);

    // Known pattern: inverted response, DONE 34 / 37 cycles after acceptance.
    step(1'b1, 16'hA5C3, 1'b0);
    for (int c = 0; c < 34; c++) step(1'b0, 16'($urandom), 1'b0);
    check("resp_a5c3_cap1", resp[0], 16'h5A3C);
    check("done_at_34", {15'd0, done[0]}, 16'h0001);
    for (int c = 0; c < 3; c++) step(1'b0, 16'($urandom), 1'b0);
    check("resp_a5c3_cap4", resp[1], 16'hA5C3);
    check("done_at_37", {15'd0, done[1]}, 16'h0001);
    for (int c = 0; c < 4; c++) step(1'b0, 16'($urandom), 1'b0);

    // START held high: back-to-back runs, random PAT each cycle.
    for (int c = 0; c < 120; c++) step(1'b1, 16'($urandom), 1'b0);
    for (int c = 0; c < 40; c++)  step(1'b0, 16'($urandom), 1'b0);

    // PAT=0: SO stuck at 1 through the CAP_CYC=1 unload.
    step(1'b1, 16'h0000, 1'b0);
    for (int c = 0; c < 40; c++) step(1'b0, 16'($urandom), 1'b0);
    check("resp_ones", resp[0], 16'hFFFF);

    // Reset in UNLOAD cycle 5 of the CAP_CYC=1 controller.
    step(1'b1, 16'($urandom), 1'b0);
    for (int c = 0; c < 22; c++) step(1'b0, 16'($urandom), 1'b0);
    step(1'b0, 16'($urandom), 1'b1);
    step(1'b0, 16'($urandom), 1'b0);
    check("abort_resp", resp[0], 16'h0000);
    for (int c = 0; c < 40; c++) step(1'b0, 16'($urandom), 1'b0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 900; c++) begin
      step(logic'($urandom_range(0, 3) == 0), 16'($urandom), logic'($urandom_range(0, 299) == 0));
    end
    step(1'b0, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
